// File: rtl/pll_sched_pkg.sv
// Shared widths, command field offsets and FSM encodings for the ADF4159 load scheduler.
package pll_sched_pkg;

  localparam int INT_W  = 12;
  localparam int FRAC_W = 25;
  localparam int LO_W   = 4;
  localparam int CH_W   = 4;

  localparam int CMD_CH_LSB   = 0;
  localparam int CMD_INT_LSB  = 4;
  localparam int CMD_FRAC_LSB = 16;
  localparam int CMD_LO_LSB   = 41;
  localparam int CMD_W        = 45;

  typedef enum logic [1:0] {
    LD_IDLE      = 2'd0,
    LD_WAIT_FREE = 2'd1,
    LD_ASSERT    = 2'd2,
    LD_DONE      = 2'd3
  } ld_state_e;

  typedef enum logic [1:0] {
    CMD_IDLE     = 2'd0,
    CMD_LATCH    = 2'd1,
    CMD_ACK_WAIT = 2'd2
  } cmd_state_e;

endpackage

// File: rtl/pll_load_ch.sv
// One channel's load sequencer: copies shadow to active words, then runs the
// load/busy handshake. Optional watchdog under PLL_LOAD_TIMEOUT_EN.
module pll_load_ch
  import pll_sched_pkg::*;
#(
  parameter logic [INT_W-1:0]  INT_DEF_C  = '0,
  parameter logic [FRAC_W-1:0] FRAC_DEF_C = '0,
  parameter int                TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pend,
  input  logic              busy,
  input  logic [INT_W-1:0]  sh_int,
  input  logic [FRAC_W-1:0] sh_frac,
  input  logic [LO_W-1:0]   sh_lo,
  output logic              pend_clr,
  output logic              load,
  output logic [INT_W-1:0]  act_int,
  output logic [FRAC_W-1:0] act_frac,
  output logic [LO_W-1:0]   act_lo,
  output logic              timeout_flag
);

  ld_state_e state;
  logic      wd_fire;

  assign pend_clr = (state == LD_IDLE) && pend;

`ifdef PLL_LOAD_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
  logic [31:0] wd_cnt;
  logic        wd_run;

  assign wd_run  = (state == LD_WAIT_FREE) || (state == LD_ASSERT);
  assign wd_fire = wd_run && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst || !wd_run) wd_cnt <= '0;
    else                wd_cnt <= wd_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)          timeout_flag <= 1'b0;
    else if (wd_fire) timeout_flag <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign wd_fire        = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_IDLE;
      load     <= 1'b0;
      act_int  <= INT_DEF_C;
      act_frac <= FRAC_DEF_C;
      act_lo   <= '0;
    end else if (wd_fire) begin
      load  <= 1'b0;
      state <= LD_IDLE;
    end else begin
      unique case (state)
        LD_IDLE: if (pend) begin
          act_int  <= sh_int;
          act_frac <= sh_frac;
          act_lo   <= sh_lo;
          state    <= LD_WAIT_FREE;
        end
        LD_WAIT_FREE: if (!busy) begin
          load  <= 1'b1;
          state <= LD_ASSERT;
        end
        LD_ASSERT: if (busy) begin
          load  <= 1'b0;
          state <= LD_DONE;
        end
        LD_DONE: state <= LD_IDLE;
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pll_load_sched.sv
// ADF4159 load scheduler: SPI command shadowing, trigger sync and per-channel loads.
// Optional busy watchdog enabled by defining PLL_LOAD_TIMEOUT_EN.
module pll_load_sched
  import pll_sched_pkg::*;
#(
  parameter int                       NUM_CH     = 6,
  parameter int                       NUM_TRIG   = 2,
  parameter logic [NUM_CH*4-1:0]      TRIG_MAP   = '0,
  parameter int                       BOOT_DELAY = 1000,
  parameter int                       TIMEOUT    = 65535,
  parameter logic [NUM_CH*INT_W-1:0]  INT_DEF    = '0,
  parameter logic [NUM_CH*FRAC_W-1:0] FRAC_DEF   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CMD_W-1:0]           cmd_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ack,
  output logic                       cmd_err,
  input  logic [NUM_TRIG-1:0]        trig,
  input  logic [NUM_CH-1:0]          pll_busy,
  output logic [NUM_CH-1:0]          pll_load,
  output logic [NUM_CH*INT_W-1:0]    pll_int,
  output logic [NUM_CH*FRAC_W-1:0]   pll_frac,
  output logic [NUM_CH*LO_W-1:0]     pll_lo,
  output logic [NUM_CH-1:0]          timeout_flag
);

  localparam logic [CH_W-1:0] NUM_CH_L  = CH_W'(NUM_CH);
  localparam logic [31:0]     BOOT_LAST = 32'(BOOT_DELAY - 1);

  cmd_state_e         cmd_state;
  logic [CH_W-1:0]    cmd_ch;
  logic [INT_W-1:0]   cmd_int;
  logic [FRAC_W-1:0]  cmd_frac;
  logic [LO_W-1:0]    cmd_lo;
  logic               cmd_bad;

  logic [INT_W-1:0]   sh_int  [NUM_CH];
  logic [FRAC_W-1:0]  sh_frac [NUM_CH];
  logic [LO_W-1:0]    sh_lo   [NUM_CH];

  logic [NUM_TRIG-1:0] trig_s1, trig_s2, trig_prev, trig_edge;
  logic [NUM_CH-1:0]   trig_set, pend, pend_clr;
  logic [31:0]         boot_cnt;
  logic                boot_done, boot_fire;

  assign cmd_ch   = cmd_data[CMD_CH_LSB   +: CH_W];
  assign cmd_int  = cmd_data[CMD_INT_LSB  +: INT_W];
  assign cmd_frac = cmd_data[CMD_FRAC_LSB +: FRAC_W];
  assign cmd_lo   = cmd_data[CMD_LO_LSB   +: LO_W];
  assign cmd_bad  = (cmd_ch == '0) || (cmd_ch > NUM_CH_L);

  // Command handshake: level request, four-phase acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_state <= CMD_IDLE;
      cmd_ack   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      unique case (cmd_state)
        CMD_IDLE: if (cmd_valid) cmd_state <= CMD_LATCH;
        CMD_LATCH: begin
          cmd_ack   <= 1'b1;
          cmd_state <= CMD_ACK_WAIT;
          if (cmd_bad) cmd_err <= 1'b1;
        end
        CMD_ACK_WAIT: if (!cmd_valid) begin
          cmd_ack   <= 1'b0;
          cmd_state <= CMD_IDLE;
        end
        default: cmd_state <= CMD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        sh_int[c]  <= INT_DEF[c*INT_W +: INT_W];
        sh_frac[c] <= FRAC_DEF[c*FRAC_W +: FRAC_W];
        sh_lo[c]   <= '0;
      end else if (cmd_state == CMD_LATCH && cmd_ch == CH_W'(c + 1)) begin
        sh_int[c]  <= cmd_int;
        sh_frac[c] <= cmd_frac;
        sh_lo[c]   <= cmd_lo;
      end
    end
  end

  // Trigger synchroniser and rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_s1   <= '0;
      trig_s2   <= '0;
      trig_prev <= '0;
    end else begin
      trig_s1   <= trig;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;
    end
  end
  assign trig_edge = trig_s2 & ~trig_prev;

  assign boot_fire = !boot_done && (boot_cnt == BOOT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      boot_cnt  <= '0;
      boot_done <= 1'b0;
    end else if (!boot_done) begin
      boot_cnt  <= boot_cnt + 32'd1;
      boot_done <= boot_fire;
    end
  end

  // A new request beats the clear so an edge during the copy cycle stays queued
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | trig_set | {NUM_CH{boot_fire}};
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int TI = int'(TRIG_MAP[c*4 +: 4]);

    if (TI < NUM_TRIG) begin : g_map
      assign trig_set[c] = trig_edge[TI];
    end else begin : g_nomap
      assign trig_set[c] = 1'b0;
    end

    pll_load_ch #(
      .INT_DEF_C  (INT_DEF[c*INT_W +: INT_W]),
      .FRAC_DEF_C (FRAC_DEF[c*FRAC_W +: FRAC_W]),
      .TIMEOUT    (TIMEOUT)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .pend         (pend[c]),
      .busy         (pll_busy[c]),
      .sh_int       (sh_int[c]),
      .sh_frac      (sh_frac[c]),
      .sh_lo        (sh_lo[c]),
      .pend_clr     (pend_clr[c]),
      .load         (pll_load[c]),
      .act_int      (pll_int[c*INT_W +: INT_W]),
      .act_frac     (pll_frac[c*FRAC_W +: FRAC_W]),
      .act_lo       (pll_lo[c*LO_W +: LO_W]),
      .timeout_flag (timeout_flag[c])
    );
  end

endmodule

// File: doc/pll_load_sched.md
PLL_LOAD_SCHED -- requirements
Module: pll_load_sched

Interface
REQ-001 Parameter NUM_CH, default 6: number of ADF4159 channels (1..15).
REQ-002 Parameter NUM_TRIG, default 2: number of external frequency-trigger inputs.
REQ-003 Parameter TRIG_MAP, default 0: NUM_CH x 4-bit flat vector, channel c fires on trig[TRIG_MAP[c]].
REQ-004 Parameter BOOT_DELAY, default 1000: cycles from reset release to the boot load of all channels.
REQ-005 Parameter TIMEOUT, default 65535: busy-handshake watchdog limit in cycles.
REQ-006 Parameter INT_DEF / FRAC_DEF, default 0: NUM_CH x 12 / NUM_CH x 25 flat reset values of the active words.
REQ-007 clk  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 cmd_data  in  45  [3:0] channel number (1-based), [15:4] INT, [40:16] FRAC, [44:41] LO.
REQ-010 cmd_valid  in  1  level request from SPI slave; cmd_data stable while high.
REQ-011 cmd_ack  out  1  four-phase acknowledge.
REQ-012 cmd_err  out  1  sticky: bad channel number received; cleared by reset.
REQ-013 trig  in  NUM_TRIG  asynchronous trigger inputs, rising-edge active.
REQ-014 pll_busy  in  NUM_CH  per-channel driver busy.
REQ-015 pll_load  out  NUM_CH  per-channel driver load request.
REQ-016 pll_int / pll_frac / pll_lo  out  NUM_CH x 12 / x 25 / x 4  active words to drivers.
REQ-017 timeout_flag  out  NUM_CH  sticky per-channel watchdog flag.

Function
REQ-018 Command FSM IDLE->LATCH->ACK_WAIT: IDLE leaves on cmd_valid=1; LATCH writes channel n-1 shadow INT/FRAC/LO and sets cmd_ack=1 next cycle; ACK_WAIT clears cmd_ack and returns to IDLE the cycle cmd_valid is seen 0.
REQ-019 Channel 0 or >NUM_CH: no shadow write, cmd_err set, ack handshake still completed.
REQ-020 Each trig bit is 2-flop synchronised, rising edge detected; edge sets pend[c] of every mapped channel, 3-cycle latency input-to-pend.
REQ-021 Per-channel load FSM IDLE->WAIT_FREE->ASSERT->DONE->IDLE.
REQ-022 IDLE: pend[c]=1 -> copy shadow to active outputs, clear pend[c], go WAIT_FREE.
REQ-023 WAIT_FREE: pll_busy[c]=0 -> pll_load[c]=1, go ASSERT.
REQ-024 ASSERT: pll_busy[c]=1 -> pll_load[c]=0, go DONE; DONE lasts exactly one cycle.
REQ-025 Trigger arriving while channel not IDLE sets pend[c] again (one queued load, further edges merge).
REQ-026 Shadow write and load copy in same cycle: copy takes the pre-write shadow; new value waits for next trigger.
REQ-027 Active outputs change only on the IDLE copy, never during WAIT_FREE/ASSERT.
REQ-028 Boot: BOOT_DELAY cycles after reset release, pend set for all channels once.

Reset
REQ-029 rst: cmd_ack=0, cmd_err=0, pll_load=0, timeout_flag=0, pend=0, all FSMs IDLE, boot counter 0.
REQ-030 rst: shadow and active INT/FRAC = INT_DEF/FRAC_DEF, LO=0; reset mid-handshake drops pll_load the next cycle.

Configuration
REQ-031 Macro PLL_LOAD_TIMEOUT_EN defined: per-channel counter runs in WAIT_FREE/ASSERT; at TIMEOUT cycles set timeout_flag[c], drop pll_load[c], go IDLE.
REQ-032 Macro undefined: no counters, timeout_flag tied 0, FSM waits indefinitely.

Structure
REQ-033 Package pll_sched_pkg: field widths (12/25/4/4), cmd bit offsets, load-FSM state encoding.
REQ-034 Sub-module pll_load_ch: one per-channel load FSM plus optional watchdog, instantiated NUM_CH times by generate.

Verification
REQ-035 Reset, wait 1000 cycles -> all 6 pll_load pulse once, pll_int[0]=INT_DEF[0]; driver model busy 20 cycles.
REQ-036 cmd_data ch=5 INT=44 FRAC=31407723 LO=3, then trig edge mapped to ch 4 -> pll_int[4]=44, pll_frac[4]=31407723, one load pulse on channel 4 only.
REQ-037 cmd channel 0 and 9 -> cmd_ack completes, cmd_err=1, no shadow change.
REQ-038 Two trig edges 5 cycles apart while busy held -> exactly two load pulses, second after first DONE.
REQ-039 PLL_LOAD_TIMEOUT_EN, TIMEOUT=100, busy held 1 -> timeout_flag set at cycle 100, pll_load low; without macro pll_load stays high.
REQ-040 rst asserted in ASSERT state -> pll_load 0 next cycle, active words back to defaults.
